r2sdf_stage: RTL and testbench



---
 rtl/r2sdf_stage.sv | 205 ++++++++++++++++++++
 tb/tb_r2sdf_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: one radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency FFT stage.
//
// Each accepted sample advances a phase counter that runs modulo 2*DELAY.
//   Phase A (cnt <  DELAY): the input is pushed into the feedback delay line. Once the stage
//                           is primed, the difference leaving the delay line is multiplied by
//                           twiddle W[cnt] and emitted.
//   Phase B (cnt >= DELAY): the butterfly sum (fifo_out + in) is emitted. The difference
//                           (fifo_out - in) is pushed back into the delay line, so it leaves
//                           DELAY accepted samples later.
//
// Parameters:
//   DW    - sample component width, signed Q1.(DW-1)
//   DELAY - feedback depth D, a power of two >= 1; sub-block length is 2*D
//   SCALE - 1: arithmetic shift right by 1 on butterfly sum/diff, 0: no shift
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   in_valid         input sample present; the stage advances only when high
//   in_re, in_im     input sample components
//   out_valid        out_re/out_im hold a valid sample (registered)
//   out_re, out_im   output sample components (registered)

module r2sdf_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DELAY = 4,
  parameter int unsigned SCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im
);

  // DELAY is a power of two, so a CW-bit counter wraps at 2*DELAY by itself and its MSB
  // marks phase B.
  localparam int unsigned CW  = $clog2(2 * DELAY);
  localparam int          AMP = (1 << (DW - 1)) - 1;
  localparam real         PI  = 3.14159265358979323846;

  // Round to nearest, halves away from zero, then truncate to DW bits.
  function automatic logic [DW-1:0] tw_round(input real x);
    int v;
    if (x >= 0.0) begin
      v = $rtoi(x + 0.5);
    end else begin
      v = -$rtoi(-x + 0.5);
    end
    return v[DW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic          r_primed;
  logic          r_valid;
  logic [DW-1:0] r_out_re;
  logic [DW-1:0] r_out_im;

  // Feedback delay line as a shift register; entry DELAY-1 is the oldest.
  logic [DW-1:0] r_fifo_re [DELAY];
  logic [DW-1:0] r_fifo_im [DELAY];

  // ---------------------------------------------------------------------------
  // Twiddle ROM: W[k] = AMP * exp(-j*pi*k/DELAY), constant after elaboration
  // ---------------------------------------------------------------------------
  logic [DW-1:0] w_rom_re [DELAY];
  logic [DW-1:0] w_rom_im [DELAY];

  for (genvar k = 0; k < DELAY; k++) begin : g_rom
    localparam real Ang = PI * real'(k) / real'(DELAY);
    assign w_rom_re[k] = tw_round(real'(AMP) * $cos(Ang));
    assign w_rom_im[k] = tw_round(-real'(AMP) * $sin(Ang));
  end

  logic [DW-1:0] w_tw_re;
  logic [DW-1:0] w_tw_im;

  if (DELAY > 1) begin : g_tw_sel
    // In phase A the low counter bits are exactly the twiddle index.
    assign w_tw_re = w_rom_re[r_cnt[CW-2:0]];
    assign w_tw_im = w_rom_im[r_cnt[CW-2:0]];
  end else begin : g_tw_one
    assign w_tw_re = w_rom_re[0];
    assign w_tw_im = w_rom_im[0];
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic          w_phase_b;
  logic [DW-1:0] w_fo_re;
  logic [DW-1:0] w_fo_im;

  assign w_phase_b = r_cnt[CW-1];
  assign w_fo_re   = r_fifo_re[DELAY-1];
  assign w_fo_im   = r_fifo_im[DELAY-1];

  // Butterfly at DW+1 bits, optional /2, low DW bits kept (wraps, no saturation).
  logic signed [DW:0] w_sum_re;
  logic signed [DW:0] w_sum_im;
  logic signed [DW:0] w_dif_re;
  logic signed [DW:0] w_dif_im;

  assign w_sum_re = ($signed({w_fo_re[DW-1], w_fo_re}) + $signed({in_re[DW-1], in_re})) >>> SCALE;
  assign w_sum_im = ($signed({w_fo_im[DW-1], w_fo_im}) + $signed({in_im[DW-1], in_im})) >>> SCALE;
  assign w_dif_re = ($signed({w_fo_re[DW-1], w_fo_re}) - $signed({in_re[DW-1], in_re})) >>> SCALE;
  assign w_dif_im = ($signed({w_fo_im[DW-1], w_fo_im}) - $signed({in_im[DW-1], in_im})) >>> SCALE;

  // Complex multiply at 2*DW bits; taking bits [2DW-2:DW-1] is a floor shift by DW-1
  // followed by truncation to DW bits.
  logic signed [2*DW-1:0] w_p_rr;
  logic signed [2*DW-1:0] w_p_ii;
  logic signed [2*DW-1:0] w_p_ri;
  logic signed [2*DW-1:0] w_p_ir;
  logic signed [2*DW-1:0] w_m_re;
  logic signed [2*DW-1:0] w_m_im;
  logic [DW-1:0]          w_cm_re;
  logic [DW-1:0]          w_cm_im;

  assign w_p_rr  = $signed(w_fo_re) * $signed(w_tw_re);
  assign w_p_ii  = $signed(w_fo_im) * $signed(w_tw_im);
  assign w_p_ri  = $signed(w_fo_re) * $signed(w_tw_im);
  assign w_p_ir  = $signed(w_fo_im) * $signed(w_tw_re);
  assign w_m_re  = w_p_rr - w_p_ii;
  assign w_m_im  = w_p_ri + w_p_ir;
  assign w_cm_re = w_m_re[2*DW-2:DW-1];
  assign w_cm_im = w_m_im[2*DW-2:DW-1];

  // Bits discarded by the truncations above.
  logic w_unused;
  assign w_unused = ^{w_sum_re[DW], w_sum_im[DW], w_dif_re[DW], w_dif_im[DW],
                      w_m_re[2*DW-1], w_m_re[DW-2:0], w_m_im[2*DW-1], w_m_im[DW-2:0]};

  // Delay-line write value and output value for the current phase.
  logic [DW-1:0] w_wr_re;
  logic [DW-1:0] w_wr_im;
  logic [DW-1:0] w_res_re;
  logic [DW-1:0] w_res_im;
  logic          w_emit;

  always_comb begin
    w_wr_re  = in_re;
    w_wr_im  = in_im;
    w_res_re = w_cm_re;
    w_res_im = w_cm_im;
    if (w_phase_b) begin
      w_wr_re  = w_dif_re[DW-1:0];
      w_wr_im  = w_dif_im[DW-1:0];
      w_res_re = w_sum_re[DW-1:0];
      w_res_im = w_sum_im[DW-1:0];
    end
  end

  // Phase-A products before the first wrap come from an unfilled delay line.
  assign w_emit = in_valid && (w_phase_b || r_primed);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      r_valid <= w_emit;
      if (in_valid) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) begin
          r_primed <= 1'b1;
        end
      end
      // Output data holds across idle and suppressed cycles.
      if (w_emit) begin
        r_out_re <= w_res_re;
        r_out_im <= w_res_im;
      end
    end
  end

  // Delay-line contents need no reset: they are only observed after priming.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_fifo_re[0] <= w_wr_re;
      r_fifo_im[0] <= w_wr_im;
      for (int i = 1; i < int'(DELAY); i++) begin
        r_fifo_re[i] <= r_fifo_re[i-1];
        r_fifo_im[i] <= r_fifo_im[i-1];
      end
    end
  end

  assign out_valid = r_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;

endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: scoreboard bench for r2sdf_stage.
// Four stages (DELAY/SCALE = 1/0, 1/1, 2/0, 4/1) share one input stream. A reference model
// per stage (sample-count based phase, write history for the delay line) predicts each
// output and the cycle it must appear in; a negedge monitor pops and compares.
// Directed sequences additionally check hand-computed values.

module tb_r2sdf_stage;

  localparam int  NU = 4;
  localparam int  HN = 4096;
  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_re    = '0;
  logic [15:0] in_im    = '0;
  logic        ov  [NU];
  logic [15:0] ore [NU];
  logic [15:0] oim [NU];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   hist_re [NU][HN];
  int   hist_im [NU][HN];
  int   m_n [NU];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  r2sdf_stage #(.DW(16), .DELAY(1), .SCALE(0)) u_d1s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov[0]), .out_re(ore[0]), .out_im(oim[0]));
  r2sdf_stage #(.DW(16), .DELAY(1), .SCALE(1)) u_d1s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov[1]), .out_re(ore[1]), .out_im(oim[1]));
  r2sdf_stage #(.DW(16), .DELAY(2), .SCALE(0)) u_d2s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov[2]), .out_re(ore[2]), .out_im(oim[2]));
  r2sdf_stage #(.DW(16), .DELAY(4), .SCALE(1)) u_d4s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov[3]), .out_re(ore[3]), .out_im(oim[3]));

  function automatic int dly(int u);
    case (u)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int scl(int u);
    case (u)
      0: return 0;
      1: return 1;
      2: return 0;
      default: return 1;
    endcase
  endfunction

  // ---------------- scoreboard queues ----------------
  function automatic int qsize(int u);
    case (u)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qfront(int u);
    case (u)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  function automatic void qpop(int u);
    case (u)
      0: q0.pop_front();
      1: q1.pop_front();
      2: q2.pop_front();
      default: q3.pop_front();
    endcase
  endfunction

  function automatic void qpush(int u, int re, int im);
    exp_t e;
    e.cyc = cyc + 1;  // captured at the next posedge, visible at the following negedge
    e.re  = re[15:0];
    e.im  = im[15:0];
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic void cmp(string name, int u, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s u%0d cyc=%0d: got %h required %h", name, u, cyc, got, want);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int sx16(int v);
    logic [15:0] t;
    t = v[15:0];
    return {{16{t[15]}}, t};
  endfunction

  function automatic int rnd(real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  // Product sum kept at 32 bits, floor divide by 2^15, keep 16 bits.
  function automatic int cmul_q(longint p);
    int w;
    w = int'(p[31:0]);
    return sx16(w >>> 15);
  endfunction

  function automatic void model_step(int u, int xre, int xim);
    int d, s, n, k, fre, fim, wre, wim;
    longint pre, pim;
    d = dly(u);
    s = scl(u);
    n = m_n[u];
    k = n % (2 * d);
    fre = 0;
    fim = 0;
    if (n >= d) begin
      fre = hist_re[u][n-d];
      fim = hist_im[u][n-d];
    end
    if (k >= d) begin
      qpush(u, sx16((fre + xre) >>> s), sx16((fim + xim) >>> s));
      hist_re[u][n] = sx16((fre - xre) >>> s);
      hist_im[u][n] = sx16((fim - xim) >>> s);
    end else begin
      hist_re[u][n] = xre;
      hist_im[u][n] = xim;
      if (n >= 2 * d) begin
        wre = rnd(32767.0 * $cos(PI * real'(k) / real'(d)));
        wim = rnd(-32767.0 * $sin(PI * real'(k) / real'(d)));
        pre = longint'(fre) * longint'(wre) - longint'(fim) * longint'(wim);
        pim = longint'(fre) * longint'(wim) + longint'(fim) * longint'(wre);
        qpush(u, cmul_q(pre), cmul_q(pim));
      end
    end
    m_n[u] = n + 1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      exp_t e;
      bit   ev;
      e  = '0;
      ev = 1'b0;
      if (qsize(u) > 0) begin
        e  = qfront(u);
        ev = (e.cyc == cyc);
      end
      cmp("sb_valid", u, {31'b0, ov[u]}, {31'b0, ev});
      if (ev) begin
        qpop(u);
        cmp("sb_data", u, {ore[u], oim[u]}, {e.re, e.im});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int re, input int im);
    @(negedge clk);
    in_valid = v;
    in_re    = re[15:0];
    in_im    = im[15:0];
    if (v) begin
      for (int u = 0; u < NU; u++) model_step(u, re, im);
    end
  endtask

  // Outputs seen right after drive() belong to the previously driven sample.
  task automatic chk(input string nm, input int u, input bit v, input int re, input int im);
    cmp({nm, "_valid"}, u, {31'b0, ov[u]}, {31'b0, v});
    if (v) cmp({nm, "_data"}, u, {ore[u], oim[u]}, {re[15:0], im[15:0]});
  endtask

  task automatic chk_zero(input string nm);
    for (int u = 0; u < NU; u++) begin
      cmp({nm, "_valid"}, u, {31'b0, ov[u]}, 32'd0);
      cmp({nm, "_data"}, u, {ore[u], oim[u]}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    for (int u = 0; u < NU; u++) m_n[u] = 0;
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
  endtask

  function automatic int rand_s16();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    for (int u = 0; u < NU; u++) m_n[u] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;

    // DELAY=1: (100,0),(50,0),(0,0)
    drive(1'b1, 100, 0);
    drive(1'b1, 50, 0);
    chk("d1_first", 0, 1'b0, 0, 0);
    chk("d1s1_first", 1, 1'b0, 0, 0);
    drive(1'b1, 0, 0);
    chk("d1s0_sum", 0, 1'b1, 150, 0);
    chk("d1s1_sum", 1, 1'b1, 75, 0);
    drive(1'b0, 0, 0);
    chk("d1s0_twid", 0, 1'b1, 49, 0);
    chk("d1s1_twid", 1, 1'b1, 24, 0);

    // DELAY=2: (1000,0),(1000,0),(0,0),(0,0) then drain with (0,0),(0,0)
    do_reset();
    drive(1'b1, 1000, 0);
    drive(1'b1, 1000, 0);
    drive(1'b1, 0, 0);
    chk("d2_unprimed", 2, 1'b0, 0, 0);
    drive(1'b1, 0, 0);
    chk("d2_sum0", 2, 1'b1, 1000, 0);
    drive(1'b1, 0, 0);
    chk("d2_sum1", 2, 1'b1, 1000, 0);
    drive(1'b1, 0, 0);
    chk("d2_drain_k0", 2, 1'b1, 999, 0);
    drive(1'b0, 0, 0);
    chk("d2_drain_k1", 2, 1'b1, 0, -1000);

    // Sum overflow wraps rather than saturating
    do_reset();
    drive(1'b1, 32767, 0);
    drive(1'b1, 32767, 0);
    drive(1'b0, 0, 0);
    chk("wrap_sum", 0, 1'b1, -2, 0);

    // Random stream with pseudo-random gaps
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_s16(), rand_s16());
    end

    // Reset mid-frame at cnt = D+1 of the DELAY=4 stage, then a fresh frame
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, rand_s16(), rand_s16());
    do_reset();
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 4) != 0, rand_s16(), rand_s16());
    end

    repeat (4) drive(1'b0, 0, 0);
    @(negedge clk);
    for (int u = 0; u < NU; u++) cmp("sb_drained", u, qsize(u), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
